lsu: RTL and testbench

//  Load/store unit: responder for the mem_read/mem_write commands from the core decoder.

---
 rtl/lsu_pkg.sv | 65 ++++++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu.sv | 162 ++++++++++++++++
 tb/tb_lsu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: decoder load/store encodings,
// the LSU FSM state, access-size classification and address alignment helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_BYTE,
        LD_HALF,
        LD_WORD,
        LD_BYTE_U,
        LD_HALF_U
    } mem_read_t;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_BYTE,
        ST_HALF,
        ST_WORD
    } mem_write_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_t;

    // Size of the access actually performed; a store always takes precedence.
    function automatic acc_size_t access_size(input mem_read_t ld, input mem_write_t st);
        acc_size_t sz;
        sz = SZ_BYTE;
        if (st != ST_NONE) begin
            case (st)
                ST_HALF: sz = SZ_HALF;
                ST_WORD: sz = SZ_WORD;
                default: sz = SZ_BYTE;
            endcase
        end else begin
            case (ld)
                LD_HALF, LD_HALF_U: sz = SZ_HALF;
                LD_WORD:            sz = SZ_WORD;
                default:            sz = SZ_BYTE;
            endcase
        end
        return sz;
    endfunction

    // Clears the low address bits that a naturally aligned access of this size cannot use.
    function automatic logic [1:0] force_align(input acc_size_t sz, input logic [1:0] o);
        logic [1:0] r;
        case (sz)
            SZ_HALF: r = {o[1], 1'b0};
            SZ_WORD: r = 2'b00;
            default: r = o;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane formatting for the LSU: store byte enables / replicated write data,
// and load right-shift with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  mem_read_t   ld_type,
    input  mem_write_t  st_type,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lanes,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Store side: enable the addressed lanes and replicate the data into every lane.
    always_comb begin
        wstrb       = 4'b0000;
        wdata_lanes = st_data;
        case (st_type)
            ST_BYTE: begin
                wstrb       = 4'b0001 << offset;
                wdata_lanes = {4{st_data[7:0]}};
            end
            ST_HALF: begin
                wstrb       = 4'b0011 << offset;
                wdata_lanes = {2{st_data[15:0]}};
            end
            ST_WORD: wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    // Load side: bring the addressed byte/half down to bit 0, then extend.
    always_comb begin
        shifted = raw_rdata >> {offset, 3'b000};
        ld_data = shifted;
        case (ld_type)
            LD_BYTE:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LD_BYTE_U: ld_data = {24'h000000, shifted[7:0]};
            LD_HALF:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LD_HALF_U: ld_data = {16'h0000, shifted[15:0]};
            default:   ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns decoder mem_read/mem_write commands into single
// req/gnt/rvalid bus transactions and stalls the core until each completes.
// Handshake: bus_req is held with stable fields until the cycle bus_gnt is seen;
// for loads the data arrives on the first bus_rvalid at or after that grant.
// A watchdog (TIMEOUT cycles, 0 = off) aborts a stuck access with bus_err.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are rejected
// with a misaligned pulse instead of being force-aligned.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_read_t   mem_read,
    input  mem_write_t  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output lsu_state_t  state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t  state_next;
    mem_read_t   ld_q;
    mem_write_t  st_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [CW-1:0] wd_cnt;

    logic        store_in;
    logic        active;
    mem_read_t   ld_eff;
    acc_size_t   sz_in;
    logic        trap_hit;
    logic        is_load_q;
    logic        wd_expired;
    logic        capture;
    logic        timeout_fire;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] ld_data;

    assign store_in  = (mem_write != ST_NONE);
    assign active    = store_in || (mem_read != LD_NONE);
    assign ld_eff    = store_in ? LD_NONE : mem_read;
    assign sz_in     = access_size(ld_eff, mem_write);
    assign is_load_q = (ld_q != LD_NONE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_hit = ((sz_in == SZ_HALF) && addr[0]) ||
                      ((sz_in == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    assign trap_hit = 1'b0;
`endif

    assign wd_expired   = (TIMEOUT != 0) && (wd_cnt == CW'(TIMEOUT - 1));
    assign capture      = is_load_q && bus_rvalid &&
                          (((state == LSU_REQ) && bus_gnt) || (state == LSU_WAIT));
    assign timeout_fire = wd_expired &&
                          (((state == LSU_REQ) && !bus_gnt) ||
                           ((state == LSU_WAIT) && !bus_rvalid));

    lsu_align u_align (
        .ld_type     (ld_q),
        .st_type     (st_q),
        .offset      (addr_q[1:0]),
        .st_data     (wdata_q),
        .raw_rdata   (bus_rdata),
        .wstrb       (lane_strb),
        .wdata_lanes (lane_wdata),
        .ld_data     (ld_data)
    );

    // FSM state register; reset drops any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and bus/stall outputs.
    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_wstrb  = 4'b0000;
        bus_addr   = {addr_q[31:2], 2'b00};
        bus_wdata  = lane_wdata;
        stall      = active && (state != LSU_DONE);
        case (state)
            LSU_IDLE: begin
                if (active) state_next = trap_hit ? LSU_DONE : LSU_REQ;
            end
            LSU_REQ: begin
                bus_req   = 1'b1;
                bus_we    = (st_q != ST_NONE);
                bus_wstrb = (st_q != ST_NONE) ? lane_strb : 4'b0000;
                if (bus_gnt)         state_next = (!is_load_q || bus_rvalid) ? LSU_DONE : LSU_WAIT;
                else if (wd_expired) state_next = LSU_DONE;
            end
            LSU_WAIT: begin
                if (bus_rvalid || wd_expired) state_next = LSU_DONE;
            end
            LSU_DONE: state_next = LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    // Latch the command when leaving IDLE so the bus fields stay stable while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q    <= LD_NONE;
            st_q    <= ST_NONE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if ((state == LSU_IDLE) && active) begin
            ld_q    <= ld_eff;
            st_q    <= mem_write;
            addr_q  <= {addr[31:2], force_align(sz_in, addr[1:0])};
            wdata_q <= wdata;
        end
    end

    // Watchdog: restarts on every entry to REQ or WAIT, counts while waiting there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if ((state_next != state) &&
                     ((state_next == LSU_REQ) || (state_next == LSU_WAIT))) begin
            wd_cnt <= '0;
        end else if ((state == LSU_REQ) || (state == LSU_WAIT)) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end

    // Load result and the single-cycle status pulses, all visible during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata      <= 32'h0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            misaligned <= (state == LSU_IDLE) && active && trap_hit;
            bus_err    <= timeout_fire;
            if (capture)           rdata <= ld_data;
            else if (timeout_fire) rdata <= 32'h0;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed load/store vectors, a cycle-level model of the
// expected bus/stall behaviour, and a negedge compare process with an
// expected-rdata queue. Honours LSU_MISALIGN_TRAP_EN when the build defines it.
module tb_lsu;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    mem_read_t   mem_read;
    mem_write_t  mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    lsu_state_t  state;

    lsu #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .state      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    logic        chk_on;
    logic        exp_stall, exp_req, exp_we, exp_mis, exp_err, exp_rd_chk, exp_chk_state;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, want, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] model_addr(input mem_read_t ld, input mem_write_t st,
                                               input logic [31:0] a);
        int bytes;
        bytes = 1;
        if (st == ST_HALF || (st == ST_NONE && (ld == LD_HALF || ld == LD_HALF_U))) bytes = 2;
        if (st == ST_WORD || (st == ST_NONE && ld == LD_WORD)) bytes = 4;
        return a - (a % bytes);
    endfunction

    function automatic logic [3:0] model_wstrb(input mem_write_t st, input logic [1:0] o);
        case (st)
            ST_BYTE: return 4'(32'd1 << o);
            ST_HALF: return 4'(32'd3 << o);
            ST_WORD: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input mem_write_t st, input logic [31:0] d);
        case (st)
            ST_BYTE: return (d & 32'hFF) * 32'h01010101;
            ST_HALF: return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input mem_read_t ld, input logic [31:0] w,
                                               input logic [1:0] o);
        logic [31:0] s, v;
        s = w >> (8 * o);
        case (ld)
            LD_BYTE:   begin v = s & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFFFF00; end
            LD_BYTE_U: v = s & 32'hFF;
            LD_HALF:   begin v = s & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF0000; end
            LD_HALF_U: v = s & 32'hFFFF;
            default:   v = s;
        endcase
        return v;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic bit model_mis(input mem_read_t ld, input mem_write_t st,
                                     input logic [31:0] a);
        return model_addr(ld, st, a) != a;
    endfunction
`endif

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("bus_req", 32'(bus_req), 32'(exp_req));
            check("misaligned", 32'(misaligned), 32'(exp_mis));
            check("bus_err", 32'(bus_err), 32'(exp_err));
            if (exp_req) begin
                check("bus_addr", bus_addr, exp_addr);
                check("bus_we", 32'(bus_we), 32'(exp_we));
                if (exp_we) begin
                    check("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
                    check("bus_wdata", bus_wdata, exp_wdata);
                end
            end
            if (exp_rd_chk) begin
                if (exp_q.size() == 0) check("rdata_queue_empty", 32'd0, 32'd1);
                else check("rdata", rdata, exp_q.pop_front());
            end
            if (exp_chk_state) check("state_idle", 32'(state), 32'(LSU_IDLE));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_exp();
        exp_stall = 0; exp_req = 0; exp_we = 0; exp_mis = 0; exp_err = 0;
        exp_rd_chk = 0; exp_chk_state = 0;
        exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
    endtask

    task automatic idle_inputs();
        mem_read = LD_NONE; mem_write = ST_NONE; addr = 0; wdata = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 32'hBAD0_0BAD;
    endtask

    // One access. gd = REQ cycles before grant (-1: never granted), rd = WAIT
    // cycles before rvalid, same = rvalid together with the grant.
    task automatic do_op(input mem_read_t ld, input mem_write_t st, input logic [31:0] a,
                         input logic [31:0] d, input int gd, input int rd, input bit same,
                         input logic [31:0] word);
        bit is_ld, to, trap;
        int n, last_req, rv_k;
        logic [31:0] ea;
        is_ld = (st == ST_NONE) && (ld != LD_NONE);
        to    = (gd < 0);
        ea    = model_addr(ld, st, a);
        trap  = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap  = model_mis(ld, st, a);
`endif
        if (trap)    begin n = 1;      last_req = 0;  end
        else if (to) begin n = 1 + TO; last_req = TO; end
        else begin
            last_req = 1 + gd;
            n = last_req + 1 + ((is_ld && !same) ? rd + 1 : 0);
        end
        rv_k = same ? last_req : last_req + 1 + rd;
        if (is_ld && !trap) exp_q.push_back(to ? 32'h0 : model_load(ld, word, ea[1:0]));
        for (int k = 0; k <= n; k++) begin
            mem_read = ld; mem_write = st; addr = a; wdata = d;
            bus_gnt    = !to && !trap && (k == last_req);
            bus_rvalid = is_ld && !to && !trap && (k == rv_k);
            bus_rdata  = bus_rvalid ? word : 32'hBAD0_0BAD;
            clear_exp();
            exp_stall  = (k < n);
            exp_req    = !trap && (k >= 1) && (k <= last_req);
            exp_we     = (st != ST_NONE);
            exp_addr   = {ea[31:2], 2'b00};
            exp_wstrb  = model_wstrb(st, ea[1:0]);
            exp_wdata  = model_wdata(st, d);
            exp_mis    = trap && (k == n);
            exp_err    = to && (k == n);
            exp_rd_chk = is_ld && !trap && (k == n);
            chk_on = 1;
            @(posedge clk); #1;
        end
        idle_inputs();
        clear_exp();
        exp_chk_state = 1;
        @(posedge clk); #1;
    endtask

    // Reset while a load waits for data; a late rvalid must be ignored.
    task automatic do_reset_mid();
        idle_inputs(); clear_exp();
        mem_read = LD_WORD; addr = 32'h400;
        exp_stall = 1;
        @(posedge clk); #1;
        bus_gnt = 1;
        exp_req = 1; exp_addr = 32'h400;
        @(posedge clk); #1;
        rst = 1; idle_inputs(); clear_exp();
        exp_chk_state = 1; exp_rd_chk = 1; exp_q.push_back(32'h0);
        @(posedge clk); #1;
        rst = 0; bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
        clear_exp(); exp_chk_state = 1;
        @(posedge clk); #1;
        idle_inputs(); clear_exp();
        exp_chk_state = 1; exp_rd_chk = 1; exp_q.push_back(32'h0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        chk_on = 0;
        clear_exp();
        idle_inputs();
        rst = 1;

        // Pin the model against hand-computed values.
        check("pin_lh",   model_load(LD_HALF,   32'h80FF1234, 2'd2), 32'hFFFF80FF);
        check("pin_lhu",  model_load(LD_HALF_U, 32'h80FF1234, 2'd2), 32'h000080FF);
        check("pin_lb",   model_load(LD_BYTE,   32'h80FF1234, 2'd1), 32'h00000012);
        check("pin_sb_strb", 32'(model_wstrb(ST_BYTE, 2'd3)), 32'h8);
        check("pin_sb_data", model_wdata(ST_BYTE, 32'h000000A5), 32'hA5A5A5A5);
        check("pin_lw_addr", model_addr(LD_WORD, ST_NONE, 32'h102), 32'h100);

        // Reset values.
        @(negedge clk);
        check("rst_state", 32'(state), 32'(LSU_IDLE));
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        do_op(LD_NONE,   ST_WORD, 32'h100, 32'hDEADBEEF, 1, 0, 0, 32'h0);
        do_op(LD_NONE,   ST_BYTE, 32'h103, 32'h000000A5, 0, 0, 0, 32'h0);
        do_op(LD_BYTE,   ST_HALF, 32'h302, 32'h1234ABCD, 0, 0, 0, 32'h0);
        do_op(LD_NONE,   ST_HALF, 32'h105, 32'h00007E81, 2, 0, 0, 32'h0);
        do_op(LD_HALF,   ST_NONE, 32'h202, 32'h0,        0, 0, 0, 32'h80FF1234);
        do_op(LD_HALF_U, ST_NONE, 32'h202, 32'h0,        1, 1, 0, 32'h80FF1234);
        do_op(LD_BYTE,   ST_NONE, 32'h201, 32'h0,        0, 2, 0, 32'h80FF1234);
        do_op(LD_BYTE,   ST_NONE, 32'h203, 32'h0,        0, 0, 0, 32'h80FF1234);
        do_op(LD_BYTE_U, ST_NONE, 32'h203, 32'h0,        0, 0, 0, 32'h80FF1234);
        do_op(LD_WORD,   ST_NONE, 32'h102, 32'h0,        0, 0, 0, 32'hCAFEF00D);
        do_op(LD_WORD,   ST_NONE, 32'h104, 32'h0,        0, 0, 1, 32'h13572468);
        do_op(LD_WORD,   ST_NONE, 32'h500, 32'h0,        -1, 0, 0, 32'hFFFFFFFF);
        do_op(LD_HALF,   ST_NONE, 32'h206, 32'h0,        1, 0, 1, 32'h7FFE0001);
        do_reset_mid();
        do_op(LD_HALF_U, ST_NONE, 32'h20A, 32'h0,        0, 0, 0, 32'hA5C30000);

        chk_on = 0;
        @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
